// File: rtl/aq_djpeg_pkg.sv
// aq_djpeg_pkg: shared widths, write-entry layout and pixel packing for the JPEG frame-buffer writer.
package aq_djpeg_pkg;
    localparam int PIX_WORD_W = 32;
    localparam int ADDR_W     = 32;

    typedef struct packed {
        logic                  last;
        logic [ADDR_W-1:0]     addr;
        logic [PIX_WORD_W-1:0] data;
    } wr_entry_t;

    function automatic logic [PIX_WORD_W-1:0] pack_xrgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction
endpackage

// File: rtl/aq_djpeg_fbwrite_if.sv
// aq_djpeg_fbwrite_if: valid/ready write-request stream towards the memory write master.
interface aq_djpeg_fbwrite_if;
    import aq_djpeg_pkg::*;
    logic              WrValid;
    logic              WrReady;
    logic [ADDR_W-1:0] WrAddr;
    logic [PIX_WORD_W-1:0] WrData;
    logic              WrLast;

    modport master(output WrValid, WrAddr, WrData, WrLast, input WrReady);
    modport slave(input WrValid, WrAddr, WrData, WrLast, output WrReady);
endinterface

// File: rtl/aq_djpeg_fbwrite_fifo.sv
// aq_djpeg_fbwrite_fifo: single-clock FIFO of {last,addr,data}; output reads only from stored state.
module aq_djpeg_fbwrite_fifo
    import aq_djpeg_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  wr_entry_t din,
    output wr_entry_t dout,
    output logic      full,
    output logic      empty
);
    wr_entry_t mem [2**AW];
    logic [AW:0] wp, rp;
    logic wr_en, rd_en;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // Zero while empty so the stream reads all-zero straight out of reset
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];
    assign rd_en = pop & ~empty;
    assign wr_en = push & ~flush & (~full | rd_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/aq_djpeg_fbwrite.sv
// aq_djpeg_fbwrite: turns the decoder pixel stream into buffered frame-buffer write requests.
module aq_djpeg_fbwrite
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_AW  = 4,
    parameter int STRIDE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   BaseAddr,
    input  logic [STRIDE_W-1:0] Stride,
    input  logic                FrameStart,
    input  logic                PixEnable,
    input  logic [15:0]         PixX,
    input  logic [15:0]         PixY,
    input  logic [7:0]          PixR,
    input  logic [7:0]          PixG,
    input  logic [7:0]          PixB,
    input  logic [15:0]         ImgWidth,
    input  logic [15:0]         ImgHeight,
    aq_djpeg_fbwrite_if.master  wr,
    output logic                FrameDone,
    output logic                Overflow,
    output logic [15:0]         DropCount,
    output logic                Busy
);
    logic [ADDR_W-1:0]     base_q, s1_row, s1_col, s2_addr;
    logic [STRIDE_W-1:0]   stride_q;
    logic [31:0]           pix_cnt, area;
    logic [PIX_WORD_W-1:0] s1_data, s2_data;
    logic                  s1_v, s1_last, s2_v, s2_last;
    logic                  full, empty, push, pop, drop;
    wr_entry_t             head;

    assign pop  = wr.WrValid & wr.WrReady;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push = s2_v & ~FrameStart & (~full | pop);
    assign drop = s2_v & ~FrameStart & full & ~pop;

    assign wr.WrValid = ~empty;
    assign wr.WrAddr  = head.addr;
    assign wr.WrData  = head.data;
    assign wr.WrLast  = head.last;
    assign Busy       = ~empty | s1_v | s2_v;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            stride_q  <= '0;
            pix_cnt   <= '0;
            area      <= '0;
            s1_v      <= 1'b0;
            s1_row    <= '0;
            s1_col    <= '0;
            s1_data   <= '0;
            s1_last   <= 1'b0;
            s2_v      <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            s2_last   <= 1'b0;
            FrameDone <= 1'b0;
            Overflow  <= 1'b0;
            DropCount <= '0;
        end else begin
            area      <= 32'(ImgWidth) * 32'(ImgHeight);
            s1_v      <= PixEnable & ~FrameStart;
            s1_row    <= 32'(PixY) * 32'(stride_q);
            s1_col    <= {14'b0, PixX, 2'b00};
            s1_data   <= pack_xrgb(PixR, PixG, PixB);
            s1_last   <= pix_cnt == area - 32'd1;
            s2_v      <= s1_v & ~FrameStart;
            s2_addr   <= base_q + s1_row + s1_col;
            s2_data   <= s1_data;
            s2_last   <= s1_last;
            FrameDone <= pop & head.last;
            if (FrameStart) begin
                base_q    <= BaseAddr;
                stride_q  <= Stride;
                pix_cnt   <= '0;
                Overflow  <= 1'b0;
                DropCount <= '0;
            end else begin
                if (PixEnable) pix_cnt <= pix_cnt + 32'd1;
                if (drop) begin
                    Overflow <= 1'b1;
                    if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
                end
            end
        end
    end

    aq_djpeg_fbwrite_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (FrameStart),
        .push  (push),
        .pop   (pop),
        .din   ('{last: s2_last, addr: s2_addr, data: s2_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_aq_djpeg_fbwrite.sv
// tb_aq_djpeg_fbwrite: scoreboard bench for the frame-buffer writer.
module tb_aq_djpeg_fbwrite;
    typedef logic [64:0] ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] BaseAddr = '0;
    logic [15:0] Stride = '0;
    logic        FrameStart = 1'b0;
    logic        PixEnable = 1'b0;
    logic [15:0] PixX = '0, PixY = '0;
    logic [7:0]  PixR = '0, PixG = '0, PixB = '0;
    logic [15:0] ImgWidth = 16'd100, ImgHeight = 16'd100;
    logic        FrameDone, Overflow, Busy;
    logic [15:0] DropCount;

    int   n_cmp = 0, n_err = 0, hs_cnt = 0, fd_cnt = 0;
    int   bcnt = 0;
    logic [31:0] base_m = '0;
    logic [15:0] stride_m = '0;
    ent_t q[$];
    ent_t e;
    logic prev_stall = 1'b0, fd_exp = 1'b0;
    logic [64:0] st_val = '0;

    aq_djpeg_fbwrite_if wr();

    aq_djpeg_fbwrite dut (
        .clk(clk), .rst(rst), .BaseAddr(BaseAddr), .Stride(Stride), .FrameStart(FrameStart),
        .PixEnable(PixEnable), .PixX(PixX), .PixY(PixY), .PixR(PixR), .PixG(PixG), .PixB(PixB),
        .ImgWidth(ImgWidth), .ImgHeight(ImgHeight), .wr(wr), .FrameDone(FrameDone),
        .Overflow(Overflow), .DropCount(DropCount), .Busy(Busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst) begin
        if (prev_stall && wr.WrValid) begin
            n_cmp++;
            if ({wr.WrLast, wr.WrAddr, wr.WrData} !== st_val) begin
                n_err++;
                $display("FAIL stall_hold got=%h exp=%h", {wr.WrLast, wr.WrAddr, wr.WrData}, st_val);
            end
        end
        prev_stall = wr.WrValid && !wr.WrReady;
        st_val = {wr.WrLast, wr.WrAddr, wr.WrData};
        if (FrameDone || fd_exp) begin
            n_cmp++;
            if (FrameDone !== fd_exp) begin
                n_err++;
                $display("FAIL frame_done got=%b exp=%b", FrameDone, fd_exp);
            end
        end
        if (FrameDone) fd_cnt++;
        fd_exp = wr.WrValid && wr.WrReady && wr.WrLast;
        if (wr.WrValid && wr.WrReady) begin
            hs_cnt++;
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got=%h exp=none", {wr.WrLast, wr.WrAddr, wr.WrData});
            end else begin
                e = q.pop_front();
                if ({wr.WrLast, wr.WrAddr, wr.WrData} !== e) begin
                    n_err++;
                    $display("FAIL write got=%h exp=%h", {wr.WrLast, wr.WrAddr, wr.WrData}, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [31:0] b, input logic [15:0] s);
        FrameStart = 1'b1;
        BaseAddr = b;
        Stride = s;
        base_m = b;
        stride_m = s;
        tick;
        FrameStart = 1'b0;
        bcnt = 0;
    endtask

    task automatic pix(input logic [15:0] x, input logic [15:0] y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit keep);
        logic [31:0] a;
        PixEnable = 1'b1;
        PixX = x; PixY = y; PixR = r; PixG = g; PixB = b;
        a = base_m + 32'(y) * 32'(stride_m) + 32'(x) * 32'd4;
        if (keep) q.push_back({(32'(bcnt) == 32'(ImgWidth) * 32'(ImgHeight) - 32'd1), a, 8'h00, r, g, b});
        bcnt++;
        tick;
        PixEnable = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((q.size() != 0 || Busy) && t < budget) begin
            tick;
            t++;
        end
        tick;
        tick;
        n_cmp++;
        if (q.size() != 0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout got=%0d_left busy=%b exp=0", q.size(), Busy);
        end
    endtask

    task automatic test_reset;
        repeat (2) tick;
        n_cmp++;
        if ({wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast, FrameDone, Overflow, DropCount, Busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast, FrameDone, Overflow, DropCount, Busy});
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single;
        ImgWidth = 16'd100; ImgHeight = 16'd100;
        wr.WrReady = 1'b1;
        frame_start(32'h1000_0000, 16'h0100);
        pix(16'd3, 16'd2, 8'h11, 8'h22, 8'h33, 1'b1);
        tick;
        n_cmp++;
        if (wr.WrValid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got=%b exp=0", wr.WrValid);
        end
        tick;
        n_cmp++;
        if ({wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast} !== {1'b1, 32'h1000_020C, 32'h0011_2233, 1'b0}) begin
            n_err++;
            $display("FAIL single_pixel got=%b/%h/%h/%b exp=1/1000020c/00112233/0",
                     wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast);
        end
        drain(20);
    endtask

    task automatic test_frame;
        int fd0, hs0;
        ImgWidth = 16'd2; ImgHeight = 16'd2;
        wr.WrReady = 1'b1;
        frame_start(32'h2000_0000, 16'h0100);
        fd0 = fd_cnt; hs0 = hs_cnt;
        pix(16'd0, 16'd0, 8'h01, 8'h02, 8'h03, 1'b1);
        pix(16'd1, 16'd0, 8'h04, 8'h05, 8'h06, 1'b1);
        pix(16'd0, 16'd1, 8'h07, 8'h08, 8'h09, 1'b1);
        pix(16'd1, 16'd1, 8'h0A, 8'h0B, 8'h0C, 1'b1);
        drain(20);
        n_cmp++;
        if (fd_cnt - fd0 != 1 || hs_cnt - hs0 != 4) begin
            n_err++;
            $display("FAIL frame_counts got=fd%0d/hs%0d exp=fd1/hs4", fd_cnt - fd0, hs_cnt - hs0);
        end
    endtask

    task automatic test_overflow;
        int hs0;
        ImgWidth = 16'd100; ImgHeight = 16'd100;
        wr.WrReady = 1'b0;
        frame_start(32'h0800_0000, 16'h0400);
        for (int i = 0; i < 17; i++)
            pix(16'(i), 16'd5, 8'(i), 8'(i * 3), 8'(255 - i), i < 16);
        repeat (4) tick;
        n_cmp++;
        if ({wr.WrValid, Overflow, DropCount} !== {1'b1, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL overflow got=v%b/o%b/d%0d exp=v1/o1/d1", wr.WrValid, Overflow, DropCount);
        end
        hs0 = hs_cnt;
        wr.WrReady = 1'b1;
        drain(40);
        n_cmp++;
        if (hs_cnt - hs0 != 16 || DropCount !== 16'd1) begin
            n_err++;
            $display("FAIL overflow_drain got=hs%0d/d%0d exp=hs16/d1", hs_cnt - hs0, DropCount);
        end
    endtask

    task automatic test_framestart_flush;
        int fd0;
        wr.WrReady = 1'b0;
        for (int i = 0; i < 5; i++)
            pix(16'(i), 16'd9, 8'hA0, 8'(i), 8'h5A, 1'b1);
        ImgWidth = 16'd1; ImgHeight = 16'd1;
        repeat (4) tick;
        n_cmp++;
        if ({wr.WrValid, Overflow, DropCount} !== {1'b1, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL pre_flush got=v%b/o%b/d%0d exp=v1/o1/d1", wr.WrValid, Overflow, DropCount);
        end
        q.delete();
        PixEnable = 1'b1;
        PixX = 16'd7; PixY = 16'd7; PixR = 8'hDE; PixG = 8'hAD; PixB = 8'hBE;
        frame_start(32'h5000_0000, 16'h0010);
        PixEnable = 1'b0;
        n_cmp++;
        if ({wr.WrValid, Overflow, DropCount, Busy} !== '0) begin
            n_err++;
            $display("FAIL flush got=v%b/o%b/d%0d/b%b exp=0/0/0/0", wr.WrValid, Overflow, DropCount, Busy);
        end
        fd0 = fd_cnt;
        wr.WrReady = 1'b1;
        pix(16'd2, 16'd3, 8'h12, 8'h34, 8'h56, 1'b1);
        drain(20);
        n_cmp++;
        if (fd_cnt - fd0 != 1) begin
            n_err++;
            $display("FAIL flush_pixcnt got=fd%0d exp=fd1", fd_cnt - fd0);
        end
    endtask

    task automatic test_back_to_back;
        int hs0;
        ImgWidth = 16'd100; ImgHeight = 16'd100;
        wr.WrReady = 1'b0;
        frame_start(32'h0001_0000, 16'h0200);
        hs0 = hs_cnt;
        fork
            for (int i = 0; i < 32; i++)
                pix(16'(i), 16'(i / 4), 8'(i), 8'(i + 64), 8'(i + 128), 1'b1);
            begin
                wr.WrReady = 1'b0;
                repeat (3) tick;
                for (int c = 0; c < 80; c++) begin
                    wr.WrReady = ~c[0];
                    tick;
                end
                wr.WrReady = 1'b1;
            end
        join
        drain(40);
        n_cmp++;
        if (hs_cnt - hs0 != 32 || Overflow !== 1'b0 || DropCount !== 16'd0) begin
            n_err++;
            $display("FAIL toggle_ready got=hs%0d/o%b/d%0d exp=hs32/o0/d0", hs_cnt - hs0, Overflow, DropCount);
        end
    endtask

    task automatic test_async_reset;
        int fd0;
        ImgWidth = 16'd100; ImgHeight = 16'd100;
        wr.WrReady = 1'b0;
        frame_start(32'h3000_0000, 16'h0200);
        for (int i = 0; i < 6; i++)
            pix(16'(i), 16'd1, 8'h33, 8'h44, 8'(i), 1'b1);
        n_cmp++;
        if ({wr.WrValid, Busy} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset got=v%b/b%b exp=v1/b1", wr.WrValid, Busy);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast, FrameDone, Overflow, DropCount, Busy} !== '0) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=0",
                     {wr.WrValid, wr.WrAddr, wr.WrData, wr.WrLast, FrameDone, Overflow, DropCount, Busy});
        end
        q.delete();
        #10 rst = 1'b1;
        tick;
        ImgWidth = 16'd1; ImgHeight = 16'd2;
        wr.WrReady = 1'b1;
        frame_start(32'h4000_0000, 16'h0040);
        fd0 = fd_cnt;
        pix(16'd5, 16'd0, 8'hC0, 8'hFF, 8'hEE, 1'b1);
        pix(16'd5, 16'd1, 8'hC1, 8'hFE, 8'hED, 1'b1);
        drain(20);
        n_cmp++;
        if (fd_cnt - fd0 != 1) begin
            n_err++;
            $display("FAIL post_reset_frame got=fd%0d exp=fd1", fd_cnt - fd0);
        end
    endtask

    initial begin
        wr.WrReady = 1'b0;
        test_reset;
        test_single;
        test_frame;
        test_overflow;
        test_framestart_flush;
        test_back_to_back;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
